// File: rtl/regfile_writeback_unit.sv
// Writeback queue merging ALU and load-unit results into one register-file write port.
// Optional forwarding of pending writes is enabled with the WB_BYPASS_EN macro.
module regfile_writeback_unit #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [DATA_W-1:0]        alu_data,

    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [DATA_W-1:0]        mem_data,

    output logic                     regwrite,
    output logic [4:0]               write_reg,
    output logic [DATA_W-1:0]        write_data,

    input  logic [4:0]               byp_rs1,
    input  logic [4:0]               byp_rs2,
    output logic                     byp_hit1,
    output logic [DATA_W-1:0]        byp_data1,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_data2,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [4:0]        rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  rptr_q;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  wptr_d;
    logic [PTR_W-1:0]  alu_slot;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  free_slots;

    logic              regwrite_q;
    logic [4:0]        write_reg_q;
    logic [DATA_W-1:0] write_data_q;

    logic              mem_fire;
    logic              alu_fire;
    logic              mem_push;
    logic              alu_push;
    logic              pop;
    logic [1:0]        push_n;

    // Readiness looks only at start-of-cycle occupancy; the load channel wins the last slot.
    always_comb begin
        free_slots = DEPTH_C - count_q;
        mem_ready  = reset && (free_slots >= CNT_W'(1));
        alu_ready  = reset && ((free_slots >= CNT_W'(2)) ||
                               ((free_slots == CNT_W'(1)) && !mem_valid));
    end

    always_comb begin
        mem_fire = mem_valid && mem_ready;
        alu_fire = alu_valid && alu_ready;
        mem_push = mem_fire && (mem_rd != 5'd0);
        alu_push = alu_fire && (alu_rd != 5'd0);
        pop      = (count_q != '0);
        push_n   = {1'b0, mem_push} + {1'b0, alu_push};
        alu_slot = wptr_q + PTR_W'(mem_push);
        wptr_d   = wptr_q + PTR_W'(push_n);
        count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop);
    end

    // Entry storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (mem_push) begin
            rd_q[wptr_q]   <= mem_rd;
            data_q[wptr_q] <= mem_data;
        end
        if (alu_push) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
        end else begin
            rptr_q     <= rptr_q + PTR_W'(pop);
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            regwrite_q <= pop;
            if (pop) begin
                write_reg_q  <= rd_q[rptr_q];
                write_data_q <= data_q[rptr_q];
            end
        end
    end

    always_comb begin
        regwrite   = regwrite_q;
        write_reg  = write_reg_q;
        write_data = write_data_q;
        count      = count_q;
        full       = (count_q == DEPTH_C);
        empty      = (count_q == '0);
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        idx       = '0;
        if (regwrite_q) begin
            if (write_reg_q == byp_rs1) begin
                byp_hit1  = 1'b1;
                byp_data1 = write_data_q;
            end
            if (write_reg_q == byp_rs2) begin
                byp_hit2  = 1'b1;
                byp_data2 = write_data_q;
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                idx = rptr_q + PTR_W'(i);
                if (rd_q[idx] == byp_rs1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_q[idx];
                end
                if (rd_q[idx] == byp_rs2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_q[idx];
                end
            end
        end
        if (byp_rs1 == 5'd0) begin
            byp_hit1  = 1'b0;
            byp_data1 = '0;
        end
        if (byp_rs2 == 5'd0) begin
            byp_hit2  = 1'b0;
            byp_data2 = '0;
        end
    end
`else
    logic unused_byp;

    assign unused_byp = ^{byp_rs1, byp_rs2};
    assign byp_hit1   = 1'b0;
    assign byp_data1  = '0;
    assign byp_hit2   = 1'b0;
    assign byp_data2  = '0;
`endif

endmodule

// File: doc/regfile_writeback_unit.md
REGFILE_WRITEBACK_UNIT -- requirements
Module: regfile_writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queued writeback entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the writeback data width.
REQ-003 SHALL have port clock  in  1  system clock, rising-edge active.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-low (asserted when 0).
REQ-005 SHALL have port alu_valid/alu_ready/alu_rd/alu_data  in/out/in/in  1/1/5/DATA_W  ALU writeback request channel.
REQ-006 SHALL have port mem_valid/mem_ready/mem_rd/mem_data  in/out/in/in  1/1/5/DATA_W  load-unit writeback request channel.
REQ-007 SHALL have port regwrite/write_reg/write_data  out/out/out  1/5/DATA_W  register-file write port, driven from registers.
REQ-008 SHALL have port byp_rs1/byp_rs2  in  5 each  source register numbers to look up.
REQ-009 SHALL have port byp_hit1/byp_data1/byp_hit2/byp_data2  out  1/DATA_W/1/DATA_W  pending-write forwarding results.
REQ-010 SHALL have port count/full/empty  out  clog2(DEPTH)+1/1/1  queue occupancy status.

Function
REQ-011 SHALL complete a handshake on a channel when valid and ready are both 1 at a rising clock edge.
REQ-012 SHALL derive ready from the occupancy at the start of the cycle only; a same-cycle dequeue SHALL NOT free a slot.
REQ-013 SHALL drive mem_ready=1 when free slots >= 1.
REQ-014 SHALL drive alu_ready=1 when free slots >= 2, or when free slots == 1 and mem_valid=0 (load has priority).
REQ-015 SHALL, when both channels handshake in one cycle, enqueue the mem entry first (older) and the alu entry second.
REQ-016 SHALL complete the handshake of any request with rd==0 but SHALL NOT enqueue it.
REQ-017 SHALL, on each edge with the queue non-empty, pop the head and register regwrite=1 with the head's write_reg and write_data for exactly one cycle.
REQ-018 SHALL otherwise register regwrite=0, leaving write_reg and write_data holding their last values.
REQ-019 SHALL issue an entry accepted at edge N no earlier than edge N+1, so the register file commits it at edge N+2; drain rate SHALL be one entry per cycle, in FIFO order.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; count SHALL equal entries stored, with full=(count==DEPTH) and empty=(count==0).
REQ-021 SHALL look up bypass combinationally over all queued entries plus the entry on the write port while regwrite=1; the youngest match SHALL win.
REQ-022 SHALL drive byp_hitN=0 and byp_dataN=0 on a miss and whenever byp_rsN==0.

Reset
REQ-023 SHALL, with reset=0 at an edge, set count=0, empty=1, full=0, regwrite=0, write_reg=0 and write_data=0, and reset both pointers to 0.
REQ-024 SHALL discard all queued entries and any handshake in the reset cycle when reset is asserted mid-operation, and SHALL drive alu_ready=0 and mem_ready=0 while reset=0.

Configuration
REQ-025 SHALL, with macro WB_BYPASS_EN defined, implement the forwarding behaviour of REQ-021 and REQ-022.
REQ-026 SHALL, without WB_BYPASS_EN, keep the bypass ports but tie byp_hit1/byp_hit2 to 0 and byp_data1/byp_data2 to 0; all other behaviour SHALL be unchanged.

Verification
REQ-027 SHALL cover: alu_valid=1, rd=5, data=0x14 at edge 1 -> regwrite=1, write_reg=5, write_data=0x14 during cycle after edge 2 only.
REQ-028 SHALL cover: both channels valid with 4 free slots, mem rd=3/0x1E, alu rd=4/0x28 -> write rd3 on the first issue cycle, rd4 on the next.
REQ-029 SHALL cover: alu_valid=1, rd=0, data=0xFF -> handshake completes, count stays 0, regwrite stays 0.
REQ-030 SHALL cover: fill to count=4 while the regfile is draining and mem_valid=1 at count=4 -> mem_ready=0 that cycle, and count never exceeds 4.
REQ-031 SHALL cover: queue rd=7 with 0x11 then rd=7 with 0x22, byp_rs1=7 -> byp_hit1=1 and byp_data1=0x22 (with WB_BYPASS_EN); without the macro -> byp_hit1=0.
REQ-032 SHALL cover: reset=0 for one edge with 3 entries queued -> count=0, regwrite=0 next cycle, and no stale write issued afterwards.
